vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module  : vram_arbiter
// Brief   : Arbitrates CPU and display-refresh pixel access to a 12-bit SRAM;
//           each 24-bit pixel occupies two consecutive SRAM words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
    parameter int STROBE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [23:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [23:0] cpu_rdata,
    input  logic        dsp_req,
    input  logic [18:0] dsp_addr,
    output logic        dsp_ack,
    output logic [23:0] dsp_rdata,
    output logic [19:0] sram_a,
    output logic        sram_csb,
    output logic        sram_oeb,
    output logic        sram_web,
    input  logic [11:0] sram_d_in,
    output logic [11:0] sram_d_out,
    output logic        sram_d_oe,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_HI = 3'd1,
        RD_LO = 3'd2,
        WS_HI = 3'd3,
        WP_HI = 3'd4,
        WS_LO = 3'd5,
        WP_LO = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [3:0] PH_LAST = 4'(STROBE - 1);

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [2:0]  starve_q, starve_d;
    logic        owner_cpu_q, owner_cpu_d;
    logic [11:0] rhi_q, rhi_d;
    logic [11:0] wlo_q, wlo_d;
    logic [19:0] sram_a_q, sram_a_d;
    logic [11:0] d_out_q, d_out_d;
    logic [23:0] cpu_rdata_q, cpu_rdata_d;
    logic [23:0] dsp_rdata_q, dsp_rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dsp_ack_q, dsp_ack_d;
    logic        csb_q, csb_d;
    logic        oeb_q, oeb_d;
    logic        web_q, web_d;
    logic        d_oe_q, d_oe_d;
    logic        busy_q, busy_d;
    logic        grant_cpu, grant_dsp;

    // CPU wins a contended IDLE only after being passed over four times
    assign grant_cpu = cpu_req && (!dsp_req || (starve_q == 3'd4));
    assign grant_dsp = dsp_req && !grant_cpu;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        starve_d    = starve_q;
        owner_cpu_d = owner_cpu_q;
        rhi_d       = rhi_q;
        wlo_d       = wlo_q;
        sram_a_d    = sram_a_q;
        d_out_d     = d_out_q;
        cpu_rdata_d = cpu_rdata_q;
        dsp_rdata_d = dsp_rdata_q;
        cpu_ack_d   = 1'b0;
        dsp_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = 4'd0;
                if (!cpu_req) starve_d = 3'd0;
                if (grant_cpu) begin
                    starve_d    = 3'd0;
                    owner_cpu_d = 1'b1;
                    sram_a_d    = {cpu_addr, 1'b0};
                    if (cpu_we) begin
                        state_d = WS_HI;
                        d_out_d = cpu_wdata[23:12];
                        wlo_d   = cpu_wdata[11:0];
                    end else begin
                        state_d = RD_HI;
                    end
                end else if (grant_dsp) begin
                    if (cpu_req) starve_d = starve_q + 3'd1;
                    owner_cpu_d = 1'b0;
                    sram_a_d    = {dsp_addr, 1'b0};
                    state_d     = RD_HI;
                end
            end
            DONE: begin
                phase_d = 4'd0;
                state_d = IDLE;
            end
            default: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + 4'd1;
                end else begin
                    phase_d = 4'd0;
                    case (state_q)
                        RD_HI: begin
                            rhi_d       = sram_d_in;
                            sram_a_d[0] = 1'b1;
                            state_d     = RD_LO;
                        end
                        RD_LO: begin
                            state_d = DONE;
                            if (owner_cpu_q) begin
                                cpu_rdata_d = {rhi_q, sram_d_in};
                                cpu_ack_d   = 1'b1;
                            end else begin
                                dsp_rdata_d = {rhi_q, sram_d_in};
                                dsp_ack_d   = 1'b1;
                            end
                        end
                        WS_HI: state_d = WP_HI;
                        WP_HI: begin
                            sram_a_d[0] = 1'b1;
                            d_out_d     = wlo_q;
                            state_d     = WS_LO;
                        end
                        WS_LO: state_d = WP_LO;
                        WP_LO: begin
                            state_d   = DONE;
                            cpu_ack_d = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        // Strobes follow the next state so they are registered and glitch-free
        csb_d  = (state_d == IDLE) || (state_d == DONE);
        oeb_d  = !((state_d == RD_HI) || (state_d == RD_LO));
        web_d  = !((state_d == WP_HI) || (state_d == WP_LO));
        d_oe_d = (state_d == WS_HI) || (state_d == WP_HI) ||
                 (state_d == WS_LO) || (state_d == WP_LO);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 4'd0;
            starve_q    <= 3'd0;
            owner_cpu_q <= 1'b0;
            rhi_q       <= 12'd0;
            wlo_q       <= 12'd0;
            sram_a_q    <= 20'd0;
            d_out_q     <= 12'd0;
            cpu_rdata_q <= 24'd0;
            dsp_rdata_q <= 24'd0;
            cpu_ack_q   <= 1'b0;
            dsp_ack_q   <= 1'b0;
            csb_q       <= 1'b1;
            oeb_q       <= 1'b1;
            web_q       <= 1'b1;
            d_oe_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            starve_q    <= starve_d;
            owner_cpu_q <= owner_cpu_d;
            rhi_q       <= rhi_d;
            wlo_q       <= wlo_d;
            sram_a_q    <= sram_a_d;
            d_out_q     <= d_out_d;
            cpu_rdata_q <= cpu_rdata_d;
            dsp_rdata_q <= dsp_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dsp_ack_q   <= dsp_ack_d;
            csb_q       <= csb_d;
            oeb_q       <= oeb_d;
            web_q       <= web_d;
            d_oe_q      <= d_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign dsp_ack    = dsp_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dsp_rdata  = dsp_rdata_q;
    assign sram_a     = sram_a_q;
    assign sram_d_out = d_out_q;
    assign sram_csb   = csb_q;
    assign sram_oeb   = oeb_q;
    assign sram_web   = web_q;
    assign sram_d_oe  = d_oe_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module  : tb_vram_arbiter
// Brief   : Directed self-checking bench for vram_arbiter with STROBE=2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dsp_req;
    logic [18:0] cpu_addr, dsp_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_ack, dsp_ack;
    logic [23:0] cpu_rdata, dsp_rdata;
    logic [19:0] sram_a;
    logic        sram_csb, sram_oeb, sram_web, sram_d_oe, busy;
    logic [11:0] sram_d_in, sram_d_out;

    int checks   = 0;
    int failures = 0;

    logic [11:0] mem [logic [19:0]];

    always #5 clk = ~clk;

    vram_arbiter #(.STROBE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_ack(dsp_ack),
        .dsp_rdata(dsp_rdata), .sram_a(sram_a), .sram_csb(sram_csb),
        .sram_oeb(sram_oeb), .sram_web(sram_web), .sram_d_in(sram_d_in),
        .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .busy(busy)
    );

    // SRAM model: write on a clock edge while selected and write-enabled
    always @(posedge clk) begin
        if (!sram_csb && !sram_web) mem[sram_a] = sram_d_out;
    end

    always_comb begin
        sram_d_in = 12'h000;
        if (mem.exists(sram_a)) sram_d_in = mem[sram_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [18:0] addr, input logic [23:0] data);
        chk("wr_start_idle", {31'd0, busy}, 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                chk($sformatf("wr_a_c%0d", k), {12'd0, sram_a},
                    {12'd0, (k <= 4) ? {addr, 1'b0} : {addr, 1'b1}});
                chk($sformatf("wr_dout_c%0d", k), {20'd0, sram_d_out},
                    {20'd0, (k <= 4) ? data[23:12] : data[11:0]});
                chk($sformatf("wr_web_c%0d", k), {31'd0, sram_web},
                    (k == 3 || k == 4 || k == 7 || k == 8) ? 32'd0 : 32'd1);
                chk($sformatf("wr_csb_oe_ack_c%0d", k),
                    {29'd0, sram_csb, sram_d_oe, cpu_ack}, 32'b010);
            end else begin
                chk("wr_done", {28'd0, cpu_ack, sram_csb, sram_d_oe, sram_web}, 32'b1101);
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input bit is_cpu, input logic [18:0] addr, input logic [23:0] exp);
        logic own_ack, oth_ack;
        chk("rd_start_idle", {31'd0, busy}, 32'd0);
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        end else begin
            dsp_req = 1'b1; dsp_addr = addr;
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            own_ack = is_cpu ? cpu_ack : dsp_ack;
            oth_ack = is_cpu ? dsp_ack : cpu_ack;
            if (k <= 4) begin
                chk($sformatf("rd_a_c%0d", k), {12'd0, sram_a},
                    {12'd0, (k <= 2) ? {addr, 1'b0} : {addr, 1'b1}});
                chk($sformatf("rd_strobes_c%0d", k),
                    {27'd0, sram_oeb, sram_csb, sram_web, sram_d_oe, own_ack}, 32'b00100);
            end else begin
                chk("rd_done", {28'd0, own_ack, oth_ack, sram_oeb, sram_d_oe}, 32'b1010);
                chk("rd_data", {8'd0, is_cpu ? cpu_rdata : dsp_rdata}, {8'd0, exp});
            end
        end
        if (is_cpu) cpu_req = 1'b0; else dsp_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int dcount;
        int acks;
        bit got;
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dsp_req = 1'b0; dsp_addr = '0;
        mem[20'hFFFFE] = 12'h5A5;
        mem[20'hFFFFF] = 12'h3C3;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {28'd0, sram_csb, sram_oeb, sram_web, sram_d_oe}, 32'b1110);
        chk("rst_a_dout", {sram_a, sram_d_out}, 32'd0);
        chk("rst_ack_busy", {29'd0, cpu_ack, dsp_ack, busy}, 32'd0);
        chk("rst_rdata", {8'd0, cpu_rdata ^ dsp_rdata, cpu_rdata | dsp_rdata} , 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back one pixel
        do_write(19'h00005, 24'hABC123);
        do_read(1'b1, 19'h00005, 24'hABC123);

        // Simultaneous requests: display first, CPU right after
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00000;
        do_read(1'b0, 19'h00005, 24'hABC123);
        do_read(1'b1, 19'h00000, 24'h000000);

        // Starvation guard: four display services before the CPU
        dsp_req = 1'b1; dsp_addr = 19'h7FFFF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00005;
        dcount = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (dsp_ack) dcount++;
            if (cpu_ack) got = 1'b1;
        end
        chk("starve_cpu_ack_seen", {31'd0, got}, 32'd1);
        chk("starve_dsp_count", dcount, 32'd4);
        chk("starve_dsp_rdata", {8'd0, dsp_rdata}, 32'h005A53C3);
        cpu_req = 1'b0; dsp_req = 1'b0;
        @(negedge clk);

        // Reset during WP_HI aborts the write with no ack
        chk("rst_mid_idle", {31'd0, busy}, 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00005; cpu_wdata = 24'h111222;
        repeat (3) @(negedge clk);
        chk("rst_mid_wp_web", {30'd0, sram_web, sram_csb}, 32'b00);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rst_mid_async", {27'd0, sram_web, sram_csb, sram_oeb, sram_d_oe, busy}, 32'b11100);
        chk("rst_mid_a", {12'd0, sram_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ack || dsp_ack) acks++;
        end
        chk("rst_mid_no_ack", acks, 32'd0);
        do_write(19'h00005, 24'hABC123);
        do_read(1'b1, 19'h00005, 24'hABC123);

        // Top pixel maps to the last two words; bus never driven on reads
        do_read(1'b0, 19'h7FFFF, 24'h5A53C3);
        chk("dsp_rdata_hold", {8'd0, dsp_rdata}, 32'h005A53C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
